// File: rtl/bcd_serial_add_ctrl_pkg.sv
// Shared definitions for the serial packed-BCD adder: FSM encoding, BCD limits
// and a digit-validity helper.
package bcd_serial_add_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [3:0] BCD_MAX = 4'd9;
    localparam logic [3:0] BCD_ADJ = 4'd6;

    function automatic logic bcd_digit_invalid(input logic [3:0] d);
        return (d > BCD_MAX);
    endfunction

endpackage

// File: rtl/bcd_serial_add_ctrl_if.sv
// Operand/result bundle between the operand/display logic (master) and the
// serial BCD add controller (slave).
interface bcd_serial_add_ctrl_if #(
    parameter int NDIGITS = 4
);
    logic                   Start_in;
    logic [4*NDIGITS-1:0]   A_in;
    logic [4*NDIGITS-1:0]   B_in;
    logic                   Cin_in;
    logic                   Busy_out;
    logic                   Done_out;
    logic [4*NDIGITS-1:0]   Sum_out;
    logic                   Cout_out;
    logic                   Err_out;

    modport master (
        output Start_in, A_in, B_in, Cin_in,
        input  Busy_out, Done_out, Sum_out, Cout_out, Err_out
    );

    modport slave (
        input  Start_in, A_in, B_in, Cin_in,
        output Busy_out, Done_out, Sum_out, Cout_out, Err_out
    );
endinterface

// File: rtl/bcd_serial_add_ctrl_digit_adder.sv
// One-digit BCD adder: binary add then +6 correction when the raw sum exceeds 9.
// Invalid input digits go through the same rule; flagging them is the caller's job.
module bcd_digit_adder
    import bcd_serial_add_ctrl_pkg::*;
(
    input  logic [3:0] i_x,
    input  logic [3:0] i_y,
    input  logic       i_c,
    output logic [3:0] o_z,
    output logic       o_co
);

    logic [4:0] w_raw;
    logic [4:0] w_adj;

    // Raw 5-bit sum and decimal correction
    always_comb begin
        w_raw = {1'b0, i_x} + {1'b0, i_y} + {4'b0000, i_c};
        w_adj = w_raw + {1'b0, BCD_ADJ};
        if (w_raw > {1'b0, BCD_MAX}) begin
            o_z  = w_adj[3:0];
            o_co = 1'b1;
        end else begin
            o_z  = w_raw[3:0];
            o_co = 1'b0;
        end
    end

endmodule

// File: rtl/bcd_serial_add_ctrl.sv
// Serial packed-BCD add sequencer: latches operands on start, then pushes one
// digit pair per clock, LSD first, through a single shared digit adder.
module bcd_serial_add_ctrl
    import bcd_serial_add_ctrl_pkg::*;
#(
    parameter int NDIGITS = 4
) (
    input  logic                 Clk_in,
    input  logic                 Rst_in,
    bcd_serial_add_ctrl_if.slave bus
);

    localparam int W     = 4 * NDIGITS;
    localparam int IDX_W = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NDIGITS - 1);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [W-1:0]       r_a;
    logic [W-1:0]       r_b;
    logic [W-1:0]       r_sum;
    logic [IDX_W-1:0]   r_idx;
    logic               r_carry;
    logic               r_busy;
    logic               r_done;
    logic               r_cout;
    logic               r_err;

    logic [3:0]         w_x;
    logic [3:0]         w_y;
    logic [3:0]         w_z;
    logic               w_co;
    logic               w_last;
    logic               w_busy_nxt;
    logic               w_done_nxt;

    // Select the current digit pair from the latched operands
    always_comb begin
        w_x    = r_a[{r_idx, 2'b00} +: 4];
        w_y    = r_b[{r_idx, 2'b00} +: 4];
        w_last = (r_idx == LAST_IDX);
    end

    bcd_digit_adder u_digit_adder (
        .i_x  (w_x),
        .i_y  (w_y),
        .i_c  (r_carry),
        .o_z  (w_z),
        .o_co (w_co)
    );

    // FSM state register
    always_ff @(posedge Clk_in) begin
        if (Rst_in) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (bus.Start_in) begin
                    w_state_nxt = ST_RUN;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (w_last) begin
                    w_state_nxt = ST_DONE;
                end else begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_DONE: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // FSM output decode, registered below so Busy/Done come straight from flops
    always_comb begin
        w_busy_nxt = (w_state_nxt == ST_RUN);
        w_done_nxt = (w_state_nxt == ST_DONE);
    end

    // Datapath: operand latch, digit index, carry chain and result registers
    always_ff @(posedge Clk_in) begin
        if (Rst_in) begin
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_idx   <= '0;
            r_carry <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_cout  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_busy <= w_busy_nxt;
            r_done <= w_done_nxt;
            case (r_state)
                ST_IDLE: begin
                    if (bus.Start_in) begin
                        r_a     <= bus.A_in;
                        r_b     <= bus.B_in;
                        r_carry <= bus.Cin_in;
                        r_idx   <= '0;
                        r_err   <= 1'b0;
                        r_sum   <= '0;
                    end
                end
                ST_RUN: begin
                    r_sum[{r_idx, 2'b00} +: 4] <= w_z;
                    r_carry <= w_co;
                    if (bcd_digit_invalid(w_x) || bcd_digit_invalid(w_y)) begin
                        r_err <= 1'b1;
                    end
                    // Final carry is captured on the way into DONE so it is valid with Done
                    if (w_last) begin
                        r_cout <= w_co;
                    end else begin
                        r_idx <= r_idx + IDX_W'(1);
                    end
                end
                ST_DONE: begin
                    r_idx <= '0;
                end
                default: begin
                    r_idx <= '0;
                end
            endcase
        end
    end

    assign bus.Busy_out = r_busy;
    assign bus.Done_out = r_done;
    assign bus.Sum_out  = r_sum;
    assign bus.Cout_out = r_cout;
    assign bus.Err_out  = r_err;

endmodule

// File: tb/tb_bcd_serial_add_ctrl.sv
// Scoreboard bench for bcd_serial_add_ctrl (NDIGITS=4): expected results are queued
// at start and compared when Done_out pulses.
module tb_bcd_serial_add_ctrl;

    localparam int ND = 4;

    typedef struct packed {
        logic [15:0] sum;
        logic        cout;
        logic        err;
    } exp_t;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;
    exp_t sb[$];

    bcd_serial_add_ctrl_if #(.NDIGITS(ND)) bus ();

    bcd_serial_add_ctrl #(.NDIGITS(ND)) dut (
        .Clk_in (clk),
        .Rst_in (rst),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Decimal reference model for operands made of valid digits
    function automatic exp_t model(input logic [15:0] a, input logic [15:0] b, input logic cin);
        int   va, vb, s, p;
        exp_t e;
        va = 0; vb = 0; p = 1;
        for (int i = 0; i < ND; i++) begin
            va += int'(a[4*i +: 4]) * p;
            vb += int'(b[4*i +: 4]) * p;
            p  *= 10;
        end
        s = va + vb + int'(cin);
        e.cout = (s >= p);
        s = s % p;
        for (int i = 0; i < ND; i++) begin
            e.sum[4*i +: 4] = 4'(s % 10);
            s = s / 10;
        end
        e.err = 1'b0;
        return e;
    endfunction

    // mode 0: plain op; mode 1: extra start pulse with other operands during RUN
    task automatic do_op(input logic [15:0] a, input logic [15:0] b, input logic cin,
                         input exp_t e, input int mode);
        int   busy_cnt;
        int   done_cyc;
        int   extra;
        exp_t p;
        logic [15:0] held;
        @(negedge clk);
        bus.Start_in = 1'b1;
        bus.A_in     = a;
        bus.B_in     = b;
        bus.Cin_in   = cin;
        sb.push_back(e);
        busy_cnt = 0;
        done_cyc = 0;
        for (int cyc = 1; cyc <= 20; cyc++) begin
            @(negedge clk);
            if (cyc == 1) begin
                bus.Start_in = 1'b0;
                bus.A_in     = 16'h5555;
                bus.B_in     = 16'h4444;
                bus.Cin_in   = ~cin;
            end
            if (mode == 1 && cyc == 2) begin
                bus.Start_in = 1'b1;
                bus.A_in     = 16'h1111;
                bus.B_in     = 16'h2222;
            end
            if (mode == 1 && cyc == 3) bus.Start_in = 1'b0;
            if (bus.Busy_out) busy_cnt++;
            if (bus.Done_out) begin
                done_cyc = cyc;
                break;
            end
        end
        check_eq("done_latency", done_cyc, ND + 1);
        check_eq("busy_cycles", busy_cnt, ND);
        if (done_cyc != 0) begin
            if (sb.size() == 0) begin
                check_eq("scoreboard_empty", 32'd1, 32'd0);
            end else begin
                p = sb.pop_front();
                check_eq("sum", bus.Sum_out, p.sum);
                check_eq("cout", bus.Cout_out, p.cout);
                check_eq("err", bus.Err_out, p.err);
            end
        end else begin
            void'(sb.pop_front());
        end
        held  = bus.Sum_out;
        extra = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (bus.Done_out) extra++;
            if (bus.Busy_out) extra++;
        end
        check_eq("single_done", extra, 0);
        check_eq("sum_held", bus.Sum_out, held);
    endtask

    task automatic reset_mid_run();
        int seen;
        @(negedge clk);
        bus.Start_in = 1'b1;
        bus.A_in     = 16'h1234;
        bus.B_in     = 16'h5678;
        bus.Cin_in   = 1'b0;
        @(negedge clk);
        bus.Start_in = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_eq("rst_busy", bus.Busy_out, 1'b0);
        check_eq("rst_done", bus.Done_out, 1'b0);
        check_eq("rst_sum", bus.Sum_out, 16'h0000);
        check_eq("rst_cout", bus.Cout_out, 1'b0);
        check_eq("rst_err", bus.Err_out, 1'b0);
        rst  = 1'b0;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (bus.Done_out) seen++;
        end
        check_eq("rst_no_done", seen, 0);
    endtask

    initial begin
        logic [15:0] ra, rb;
        logic        rc;
        n_checks     = 0;
        n_fail       = 0;
        rst          = 1'b1;
        bus.Start_in = 1'b0;
        bus.A_in     = 16'h0000;
        bus.B_in     = 16'h0000;
        bus.Cin_in   = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("reset_busy", bus.Busy_out, 1'b0);
        check_eq("reset_done", bus.Done_out, 1'b0);
        check_eq("reset_sum", bus.Sum_out, 16'h0000);
        check_eq("reset_cout", bus.Cout_out, 1'b0);
        check_eq("reset_err", bus.Err_out, 1'b0);
        rst = 1'b0;

        do_op(16'h1234, 16'h5678, 1'b0, '{sum: 16'h6912, cout: 1'b0, err: 1'b0}, 0);
        do_op(16'h9999, 16'h0001, 1'b0, '{sum: 16'h0000, cout: 1'b1, err: 1'b0}, 0);
        do_op(16'h0000, 16'h0000, 1'b1, '{sum: 16'h0001, cout: 1'b0, err: 1'b0}, 0);
        do_op(16'h9999, 16'h9999, 1'b1, '{sum: 16'h9999, cout: 1'b1, err: 1'b0}, 0);
        do_op(16'h00A0, 16'h0000, 1'b0, '{sum: 16'h0100, cout: 1'b0, err: 1'b1}, 0);
        do_op(16'h0042, 16'h0058, 1'b0, '{sum: 16'h0100, cout: 1'b0, err: 1'b0}, 0);
        do_op(16'h1234, 16'h5678, 1'b0, '{sum: 16'h6912, cout: 1'b0, err: 1'b0}, 1);
        do_op(16'h9999, 16'h9999, 1'b1, '{sum: 16'h9999, cout: 1'b1, err: 1'b0}, 0);
        reset_mid_run();
        do_op(16'h0500, 16'h0499, 1'b1, '{sum: 16'h1000, cout: 1'b0, err: 1'b0}, 0);

        for (int n = 0; n < 8; n++) begin
            for (int i = 0; i < ND; i++) begin
                ra[4*i +: 4] = 4'($urandom_range(0, 9));
                rb[4*i +: 4] = 4'($urandom_range(0, 9));
            end
            rc = 1'($urandom_range(0, 1));
            do_op(ra, rb, rc, model(ra, rb, rc), 0);
        end

        check_eq("scoreboard_drained", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
